// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pending_ctrl
//  Description : Interrupt capture and arbitration stage.
//                Rising edges on irq_in are latched into a pending register
//                whatever the mask says. In IDLE, the lowest-index pending
//                source that is also enabled is captured and presented on
//                irq_out/irq_id. The request is held until ack. Edges that
//                arrive while their source is already pending are counted
//                in a saturating counter.
//  Ports       : clk          - system clock
//                reset        - synchronous reset, active-high
//                irq_in       - raw interrupt lines (same clock domain)
//                mask         - 1 = source enabled for arbitration
//                ack          - one-cycle acknowledge of the presented irq_id
//                irq_out      - interrupt request level
//                irq_id       - index of the presented interrupt
//                pending      - pending register, masked and unmasked sources
//                missed_count - saturating count of lost edges, all sources
//  Notes       : ID_W must equal $clog2(NUM_SRC).
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_pending_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2,
    parameter int OVF_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               ack,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [OVF_W-1:0]   missed_count
);

    // Width that can hold the number of edges lost in a single cycle.
    localparam int CNT_W = $clog2(NUM_SRC + 1);
    // One bit wider than either operand, so the sum cannot wrap before the
    // saturation compare.
    localparam int SUM_W = ((OVF_W > CNT_W) ? OVF_W : CNT_W) + 1;

    localparam logic [OVF_W-1:0] C_MISSED_MAX = {OVF_W{1'b1}};

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ASSERT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [NUM_SRC-1:0] r_irq_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [OVF_W-1:0]   r_missed;
    logic [OVF_W-1:0]   w_missed_nxt;
    logic [ID_W-1:0]    r_irq_id;
    logic [ID_W-1:0]    w_irq_id_nxt;
    logic               r_irq_out;
    logic               w_irq_out_nxt;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_lost;
    logic [NUM_SRC-1:0] w_req;
    logic [CNT_W-1:0]   w_lost_cnt;
    logic [SUM_W-1:0]   w_sum;
    logic [ID_W-1:0]    w_low_id;

    assign w_rise = irq_in & ~r_irq_prev;
    assign w_req  = r_pending & mask;

    // One-hot clear of the presented source when it is acknowledged.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clr
        assign w_clr[gi] = (r_state == S_ASSERT) && ack && (r_irq_id == ID_W'(gi));
    end

    // A new edge on the source being cleared wins, so it is not lost.
    assign w_lost        = w_rise & r_pending & ~w_clr;
    assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;

    always_comb begin
        w_lost_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_lost_cnt = w_lost_cnt + CNT_W'(w_lost[i]);
        end
    end

    always_comb begin
        w_sum        = SUM_W'(r_missed) + SUM_W'(w_lost_cnt);
        w_missed_nxt = (w_sum > SUM_W'(C_MISSED_MAX)) ? C_MISSED_MAX : w_sum[OVF_W-1:0];
    end

    // Lowest-index requesting source; scanning downward lets the lowest win.
    always_comb begin
        w_low_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_low_id = ID_W'(i);
            end
        end
    end

    // Next-state and output logic. irq_id/irq_out only change on the
    // IDLE->ASSERT and ASSERT->IDLE transitions, so masking a source that is
    // already being presented does not withdraw it.
    always_comb begin
        w_state_nxt   = r_state;
        w_irq_id_nxt  = r_irq_id;
        w_irq_out_nxt = r_irq_out;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_irq_id_nxt  = w_low_id;
                    w_irq_out_nxt = 1'b1;
                    w_state_nxt   = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (ack) begin
                    w_irq_out_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_irq_out_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_missed   <= '0;
            r_irq_id   <= '0;
            r_irq_out  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_irq_prev <= irq_in;
            r_pending  <= w_pending_nxt;
            r_missed   <= w_missed_nxt;
            r_irq_id   <= w_irq_id_nxt;
            r_irq_out  <= w_irq_out_nxt;
        end
    end

    assign irq_out      = r_irq_out;
    assign irq_id       = r_irq_id;
    assign pending      = r_pending;
    assign missed_count = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_pending_ctrl
//  Description : Self-checking bench for irq_pending_ctrl. Every driven cycle
//                pushes the reference model's expected post-edge outputs into
//                a queue; a monitor pops and compares after each clock edge.
//                Directed scenarios are followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_pending_ctrl;

    localparam int NUM_SRC = 4;
    localparam int ID_W    = 2;
    localparam int OVF_W   = 4;
    localparam int MISSED_MAX = (1 << OVF_W) - 1;

    logic               clk;
    logic               reset;
    logic [NUM_SRC-1:0] irq_in;
    logic [NUM_SRC-1:0] mask;
    logic               ack;
    logic               irq_out;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] pending;
    logic [OVF_W-1:0]   missed_count;

    irq_pending_ctrl #(
        .NUM_SRC(NUM_SRC),
        .ID_W   (ID_W),
        .OVF_W  (OVF_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_in      (irq_in),
        .mask        (mask),
        .ack         (ack),
        .irq_out     (irq_out),
        .irq_id      (irq_id),
        .pending     (pending),
        .missed_count(missed_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic               out;
        logic [ID_W-1:0]    id;
        logic [NUM_SRC-1:0] pend;
        logic [OVF_W-1:0]   missed;
    } exp_t;

    exp_t exp_q[$];

    // ------------------------------------------------------------------
    // Reference model: sources as arrays, counts as plain integers.
    // ------------------------------------------------------------------
    bit m_prev[NUM_SRC];
    bit m_pend[NUM_SRC];
    int m_missed;
    bit m_busy;
    int m_id;

    function automatic void model_step(input bit rst, input logic [NUM_SRC-1:0] in_v,
                                       input logic [NUM_SRC-1:0] m_v, input bit a);
        int clr_id;
        int lost;
        bit rise;
        bit np[NUM_SRC];
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                m_prev[i] = 0;
                m_pend[i] = 0;
            end
            m_missed = 0;
            m_busy   = 0;
            m_id     = 0;
            return;
        end
        clr_id = (m_busy && a) ? m_id : -1;
        lost   = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rise = in_v[i] && !m_prev[i];
            if (rise && m_pend[i] && i != clr_id) lost++;
            np[i] = rise || (m_pend[i] && i != clr_id);
        end
        m_missed = m_missed + lost;
        if (m_missed > MISSED_MAX) m_missed = MISSED_MAX;
        if (!m_busy) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (m_pend[i] && m_v[i]) begin
                    m_busy = 1;
                    m_id   = i;
                    break;
                end
            end
        end else if (a) begin
            m_busy = 0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            m_pend[i] = np[i];
            m_prev[i] = in_v[i];
        end
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.out = m_busy;
        e.id  = ID_W'(m_id);
        for (int i = 0; i < NUM_SRC; i++) e.pend[i] = m_pend[i];
        e.missed = OVF_W'(m_missed);
        return e;
    endfunction

    // Drive one cycle at the falling edge, record the expectation, and
    // return just after the rising edge that consumes the inputs.
    task automatic cyc(input bit rst, input logic [NUM_SRC-1:0] in_v,
                       input logic [NUM_SRC-1:0] m_v, input bit a);
        @(negedge clk);
        reset  = rst;
        irq_in = in_v;
        mask   = m_v;
        ack    = a;
        model_step(rst, in_v, m_v, a);
        exp_q.push_back(model_exp());
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every clock edge presents a new output set.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (irq_out !== e.out || irq_id !== e.id || pending !== e.pend ||
                missed_count !== e.missed) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got out=%0b id=%0d pend=%h missed=%0d, expected out=%0b id=%0d pend=%h missed=%0d",
                         $time, irq_out, irq_id, pending, missed_count,
                         e.out, e.id, e.pend, e.missed);
            end
        end
    end

    logic [NUM_SRC-1:0] r_in;
    logic [NUM_SRC-1:0] r_mask;

    initial begin
        reset  = 1'b1;
        irq_in = '0;
        mask   = '0;
        ack    = 1'b0;

        repeat (3) cyc(1, 4'h0, 4'hF, 0);
        chk("reset_irq_out", 32'(irq_out), 0);
        chk("reset_pending", 32'(pending), 0);
        chk("reset_missed", 32'(missed_count), 0);

        // Single pulse on source 0
        cyc(0, 4'h1, 4'hF, 0);
        chk("t1_pending", 32'(pending), 32'h1);
        chk("t1_irq_out_early", 32'(irq_out), 0);
        cyc(0, 4'h0, 4'hF, 0);
        chk("t1_irq_out", 32'(irq_out), 1);
        chk("t1_irq_id", 32'(irq_id), 0);
        cyc(0, 4'h0, 4'hF, 1);
        chk("t1_ack_out", 32'(irq_out), 0);
        chk("t1_ack_pending", 32'(pending), 0);
        repeat (2) cyc(0, 4'h0, 4'hF, 0);

        // Sources 1 and 3 together: lowest first, then one idle cycle
        cyc(0, 4'hA, 4'hF, 0);
        cyc(0, 4'h0, 4'hF, 0);
        chk("t2_first_id", 32'(irq_id), 1);
        chk("t2_first_out", 32'(irq_out), 1);
        cyc(0, 4'h0, 4'hF, 1);
        chk("t2_gap_out", 32'(irq_out), 0);
        cyc(0, 4'h0, 4'hF, 0);
        chk("t2_second_out", 32'(irq_out), 1);
        chk("t2_second_id", 32'(irq_id), 3);
        cyc(0, 4'h0, 4'hF, 1);
        repeat (2) cyc(0, 4'h0, 4'hF, 0);

        // Masked source 2 stays pending, then is unmasked
        cyc(0, 4'h4, 4'hB, 0);
        chk("t3_pending", 32'(pending), 32'h4);
        repeat (20) cyc(0, 4'h0, 4'hB, 0);
        chk("t3_masked_out", 32'(irq_out), 0);
        cyc(0, 4'h0, 4'hF, 0);
        chk("t3_unmask_out", 32'(irq_out), 1);
        chk("t3_unmask_id", 32'(irq_id), 2);
        cyc(0, 4'h0, 4'hF, 1);
        repeat (2) cyc(0, 4'h0, 4'hF, 0);

        // Periodic timer pulse on source 0, never acknowledged
        for (int t = 0; t < 170; t++) begin
            cyc(0, (t % 10 == 0) ? 4'h1 : 4'h0, 4'hF, 0);
            if (t == 10) chk("t4_missed_first", 32'(missed_count), 1);
            if (t == 20) chk("t4_missed_second", 32'(missed_count), 2);
        end
        chk("t4_missed_sat", 32'(missed_count), MISSED_MAX);
        repeat (20) cyc(0, 4'h0, 4'hF, 0);
        cyc(0, 4'h1, 4'hF, 0);
        chk("t4_missed_hold", 32'(missed_count), MISSED_MAX);

        // Ack coinciding with a new edge on the presented source
        cyc(1, 4'h0, 4'hF, 0);
        cyc(0, 4'h1, 4'hF, 0);
        cyc(0, 4'h0, 4'hF, 0);
        chk("t5_presented", 32'(irq_out), 1);
        cyc(0, 4'h1, 4'hF, 1);
        chk("t5_pending_kept", 32'(pending[0]), 1);
        chk("t5_missed", 32'(missed_count), 0);
        chk("t5_low", 32'(irq_out), 0);
        cyc(0, 4'h0, 4'hF, 0);
        chk("t5_reassert", 32'(irq_out), 1);
        cyc(0, 4'h0, 4'hF, 1);
        cyc(0, 4'h0, 4'hF, 0);

        // Reset during ASSERT with source 0 held high
        cyc(0, 4'h1, 4'hF, 0);
        cyc(0, 4'h1, 4'hF, 0);
        chk("t6_assert", 32'(irq_out), 1);
        cyc(1, 4'h1, 4'hF, 0);
        chk("t6_rst_out", 32'(irq_out), 0);
        chk("t6_rst_pending", 32'(pending), 0);
        cyc(0, 4'h1, 4'hF, 0);
        chk("t6_rel_pending", 32'(pending), 32'h1);
        cyc(0, 4'h1, 4'hF, 0);
        chk("t6_rel_out", 32'(irq_out), 1);

        // Randomized phase
        r_in   = 4'h1;
        r_mask = 4'hF;
        for (int t = 0; t < 3000; t++) begin
            r_in = r_in ^ (NUM_SRC'($urandom) & NUM_SRC'($urandom));
            if ($urandom_range(0, 15) == 0) r_mask = NUM_SRC'($urandom);
            cyc(($urandom_range(0, 299) == 0), r_in, r_mask, ($urandom_range(0, 2) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
